// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: widths, memory op codes and op decode helpers.
package mem_stage_pkg;

  localparam int unsigned REG_W     = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned MEM_BUS_W = 8;
  localparam int unsigned MEM_OP_W  = 4;

  typedef logic [MEM_OP_W-1:0] mem_op_t;

  localparam mem_op_t MEM_OP_NOP = 4'd0;
  localparam mem_op_t MEM_OP_LB  = 4'd1;
  localparam mem_op_t MEM_OP_LH  = 4'd2;
  localparam mem_op_t MEM_OP_LW  = 4'd3;
  localparam mem_op_t MEM_OP_LBU = 4'd4;
  localparam mem_op_t MEM_OP_LHU = 4'd5;
  localparam mem_op_t MEM_OP_SB  = 4'd6;
  localparam mem_op_t MEM_OP_SH  = 4'd7;
  localparam mem_op_t MEM_OP_SW  = 4'd8;

  function automatic logic op_is_mem(input mem_op_t op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
  endfunction

  function automatic logic op_is_store(input mem_op_t op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

  // Bytes moved by the op; 0 for anything that is not a memory op.
  function automatic logic [2:0] op_nbytes(input mem_op_t op);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 3'd1;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 3'd2;
      MEM_OP_LW, MEM_OP_SW:             return 3'd4;
      default:                          return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ld_ext.sv
// Sign/zero extension of the assembled load buffer according to the load op.
module mem_ld_ext
  import mem_stage_pkg::*;
(
  input  logic [3:0]  i_mem_op,
  input  logic [31:0] i_ld_buf,
  output logic [31:0] o_ld_data_c
);

  always_comb begin
    o_ld_data_c = 32'd0;
    case (i_mem_op)
      MEM_OP_LB:  o_ld_data_c = {{24{i_ld_buf[7]}}, i_ld_buf[7:0]};
      MEM_OP_LBU: o_ld_data_c = {24'd0, i_ld_buf[7:0]};
      MEM_OP_LH:  o_ld_data_c = {{16{i_ld_buf[15]}}, i_ld_buf[15:0]};
      MEM_OP_LHU: o_ld_data_c = {16'd0, i_ld_buf[15:0]};
      MEM_OP_LW:  o_ld_data_c = i_ld_buf;
      default:    o_ld_data_c = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: passes non-memory results through and serialises loads/stores
// into single-byte accesses on an 8-bit synchronous RAM port, stalling until done.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_sdata_i,
  input  logic [7:0]        ram_din_i,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_dout_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stallreq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_ld_buf;

  logic [1:0]  w_state_nxt;
  logic [2:0]  w_cnt_nxt;
  logic [31:0] w_ld_buf_nxt;

  logic        w_is_mem;
  logic        w_is_store;
  logic [2:0]  w_nbytes;
  logic [1:0]  w_ld_idx;
  logic [4:0]  w_ld_sel;
  logic [4:0]  w_st_sel;
  logic [31:0] w_addr_k;
  logic [31:0] w_ld_data;

  assign w_is_mem   = op_is_mem(mem_op_i);
  assign w_is_store = op_is_store(mem_op_i);
  assign w_nbytes   = op_nbytes(mem_op_i);
  // Byte k-1 of ld_buf receives the data for the access issued while cnt was k-1.
  assign w_ld_idx   = r_cnt[1:0] - 2'd1;
  assign w_ld_sel   = {w_ld_idx, 3'b000};
  assign w_st_sel   = {r_cnt[1:0], 3'b000};
  // cnt is 0 in IDLE, so this also yields byte 0's address there.
  assign w_addr_k   = mem_addr_i + 32'(r_cnt);

  mem_ld_ext u_ld_ext (
    .i_mem_op    (mem_op_i),
    .i_ld_buf    (r_ld_buf),
    .o_ld_data_c (w_ld_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 3'd0;
      r_ld_buf <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ld_buf <= w_ld_buf_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ld_buf_nxt = r_ld_buf;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mem) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = 3'd1;
        end
      end
      ST_BUSY: begin
        if (w_is_mem && !w_is_store) w_ld_buf_nxt[w_ld_sel +: 8] = ram_din_i;
        if (r_cnt < w_nbytes) begin
          w_cnt_nxt = r_cnt + 3'd1;
        end else begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = 3'd0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Outputs: zero-latency passthrough, RAM port drive and stall, all gated by rst.
  always_comb begin
    ram_addr_o = '0;
    ram_we_o   = 1'b0;
    ram_dout_o = 8'd0;
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'd0;
    stallreq   = 1'b0;
    if (!rst) begin
      if (!w_is_mem) begin
        wd_o    = wd_i;
        wreg_o  = wreg_i;
        wdata_o = wdata_i;
      end else begin
        wd_o = wd_i;
        case (r_state)
          ST_IDLE, ST_BUSY: begin
            stallreq = 1'b1;
            if ((r_state == ST_IDLE) || (r_cnt < w_nbytes)) begin
              ram_addr_o = w_addr_k[RAM_AW-1:0];
              if (w_is_store) begin
                ram_we_o   = 1'b1;
                ram_dout_o = mem_sdata_i[w_st_sel +: 8];
              end
            end
          end
          ST_DONE: begin
            if (!w_is_store) begin
              wreg_o  = wreg_i;
              wdata_o = w_ld_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage with a byte-wide synchronous RAM model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic [7:0]  ram_din_i;
  logic [16:0] ram_addr_o;
  logic        ram_we_o;
  logic [7:0]  ram_dout_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram [0:131071];

  always #5 clk = ~clk;

  // Read data appears the cycle after the address.
  always @(posedge clk) ram_din_i <= ram[ram_addr_o];

  mem_stage #(.RAM_AW(17)) dut (
    .clk         (clk),
    .rst         (rst),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sdata_i (mem_sdata_i),
    .ram_din_i   (ram_din_i),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_dout_o  (ram_dout_o),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stallreq    (stallreq)
  );

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] wd, input logic wr, input logic [31:0] wdat);
    mem_op_i    = op;
    mem_addr_i  = addr;
    mem_sdata_i = sd;
    wd_i        = wd;
    wreg_i      = wr;
    wdata_i     = wdat;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'd3, 32'h100, 32'hFFFF_FFFF, 5'd9, 1'b1, 32'hCAFE_F00D);
    repeat (2) @(negedge clk);
    #1;
    total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stallreq); end
    total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", ram_we_o); end
    total++; if (ram_addr_o !== 17'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", ram_addr_o); end
    total++; if (wdata_o !== 32'd0 || wreg_o !== 1'b0 || wd_o !== 5'd0) begin
      bad++; $display("FAIL rst_wb got=%h/%b/%0d exp=0/0/0", wdata_o, wreg_o, wd_o); end
    drive(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    drive(4'd0, 32'h0000_0400, 32'h55, 5'd5, 1'b1, 32'h0000_1234);
    #1;
    total++; if (wd_o !== 5'd5) begin bad++; $display("FAIL pt_wd got=%0d exp=5", wd_o); end
    total++; if (wreg_o !== 1'b1) begin bad++; $display("FAIL pt_wreg got=%b exp=1", wreg_o); end
    total++; if (wdata_o !== 32'h1234) begin bad++; $display("FAIL pt_wdata got=%h exp=00001234", wdata_o); end
    total++; if (stallreq !== 1'b0 || ram_we_o !== 1'b0) begin
      bad++; $display("FAIL pt_stall_we got=%b/%b exp=0/0", stallreq, ram_we_o); end
    @(negedge clk);
    drive(4'd12, 32'h0, 32'h0, 5'd17, 1'b0, 32'hA5A5_0001);
    #1;
    total++; if (stallreq !== 1'b0 || wdata_o !== 32'hA5A5_0001 || wd_o !== 5'd17) begin
      bad++; $display("FAIL pt_op12 got=%b/%h/%0d exp=0/a5a50001/17", stallreq, wdata_o, wd_o); end
  endtask

  task automatic test_lw();
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) drive(4'd3, 32'h100, 32'h0, 5'd3, 1'b1, 32'hDEAD_BEEF);
      #1;
      total++; if (stallreq !== (c != 5)) begin bad++; $display("FAIL lw_stall c=%0d got=%b exp=%b", c, stallreq, c != 5); end
      total++; if (ram_we_o !== 1'b0) begin bad++; $display("FAIL lw_we c=%0d got=%b exp=0", c, ram_we_o); end
      if (c <= 3) begin
        total++; if (ram_addr_o !== 17'(32'h100 + c)) begin
          bad++; $display("FAIL lw_addr c=%0d got=%h exp=%h", c, ram_addr_o, 17'(32'h100 + c)); end
      end
      if (c <= 4) begin
        total++; if (wreg_o !== 1'b0 || wdata_o !== 32'd0) begin
          bad++; $display("FAIL lw_fwd_gate c=%0d got=%b/%h exp=0/0", c, wreg_o, wdata_o); end
      end
      if (c == 5) begin
        total++; if (wdata_o !== 32'h1234_5678) begin bad++; $display("FAIL lw_data got=%h exp=12345678", wdata_o); end
        total++; if (wreg_o !== 1'b1 || wd_o !== 5'd3) begin
          bad++; $display("FAIL lw_wreg got=%b/%0d exp=1/3", wreg_o, wd_o); end
      end
      // Op still present one cycle later: back in IDLE, so byte 0 is reissued.
      if (c == 6) begin
        total++; if (ram_addr_o !== 17'h100) begin bad++; $display("FAIL lw_idle_addr got=%h exp=00100", ram_addr_o); end
      end
    end
    pulse_reset();
  endtask

  task automatic test_lb_lbu();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) drive(4'd1, 32'h200, 32'h0, 5'd4, 1'b1, 32'h0);
      if (c == 3) drive(4'd4, 32'h200, 32'h0, 5'd4, 1'b1, 32'h0);
      #1;
      total++; if (stallreq !== (c != 2 && c != 5)) begin
        bad++; $display("FAIL lb_stall c=%0d got=%b exp=%b", c, stallreq, (c != 2 && c != 5)); end
      if (c == 0 || c == 3) begin
        total++; if (ram_addr_o !== 17'h200) begin bad++; $display("FAIL lb_addr c=%0d got=%h exp=00200", c, ram_addr_o); end
      end
      if (c == 2) begin
        total++; if (wdata_o !== 32'hFFFF_FF80 || wreg_o !== 1'b1) begin
          bad++; $display("FAIL lb_data got=%h/%b exp=ffffff80/1", wdata_o, wreg_o); end
      end
      if (c == 5) begin
        total++; if (wdata_o !== 32'h0000_0080 || wreg_o !== 1'b1) begin
          bad++; $display("FAIL lbu_data got=%h/%b exp=00000080/1", wdata_o, wreg_o); end
      end
    end
    pulse_reset();
  endtask

  task automatic test_sh();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 0) drive(4'd7, 32'h301, 32'hAABB_CCDD, 5'd7, 1'b1, 32'h1111_2222);
      if (c == 4) drive(4'd0, 32'h0, 32'h0, 5'd8, 1'b1, 32'h0000_0042);
      #1;
      total++; if (ram_we_o !== (c <= 1)) begin bad++; $display("FAIL sh_we c=%0d got=%b exp=%b", c, ram_we_o, c <= 1); end
      total++; if (stallreq !== (c <= 2)) begin bad++; $display("FAIL sh_stall c=%0d got=%b exp=%b", c, stallreq, c <= 2); end
      if (c == 0) begin
        total++; if (ram_addr_o !== 17'h301 || ram_dout_o !== 8'hDD) begin
          bad++; $display("FAIL sh_b0 got=%h/%h exp=00301/dd", ram_addr_o, ram_dout_o); end
      end
      if (c == 1) begin
        total++; if (ram_addr_o !== 17'h302 || ram_dout_o !== 8'hCC) begin
          bad++; $display("FAIL sh_b1 got=%h/%h exp=00302/cc", ram_addr_o, ram_dout_o); end
      end
      if (c == 3) begin
        total++; if (wreg_o !== 1'b0 || wdata_o !== 32'd0) begin
          bad++; $display("FAIL sh_done got=%b/%h exp=0/0", wreg_o, wdata_o); end
      end
      if (c == 4) begin
        total++; if (wdata_o !== 32'h42 || wreg_o !== 1'b1) begin
          bad++; $display("FAIL sh_after got=%h/%b exp=00000042/1", wdata_o, wreg_o); end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 0) drive(4'd3, 32'h100, 32'h0, 5'd6, 1'b1, 32'h0);
      if (c == 2) rst = 1'b1;
      if (c == 3) rst = 1'b0;
      #1;
      if (c == 2) begin
        total++; if (stallreq !== 1'b0 || ram_addr_o !== 17'd0 || ram_we_o !== 1'b0) begin
          bad++; $display("FAIL rmid_gate got=%b/%h/%b exp=0/0/0", stallreq, ram_addr_o, ram_we_o); end
        total++; if (wdata_o !== 32'd0 || wd_o !== 5'd0 || wreg_o !== 1'b0) begin
          bad++; $display("FAIL rmid_wb got=%h/%0d/%b exp=0/0/0", wdata_o, wd_o, wreg_o); end
      end
      if (c >= 3 && c <= 6) begin
        total++; if (ram_addr_o !== 17'(32'h100 + c - 3)) begin
          bad++; $display("FAIL rmid_addr c=%0d got=%h exp=%h", c, ram_addr_o, 17'(32'h100 + c - 3)); end
      end
      if (c >= 3 && c <= 7) begin
        total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL rmid_stall c=%0d got=%b exp=1", c, stallreq); end
      end
      if (c == 8) begin
        total++; if (stallreq !== 1'b0 || wdata_o !== 32'h1234_5678) begin
          bad++; $display("FAIL rmid_data got=%b/%h exp=0/12345678", stallreq, wdata_o); end
      end
    end
    pulse_reset();
  endtask

  task automatic test_lh_wrap();
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c == 0) drive(4'd2, 32'hFFFF_FFFF, 32'h0, 5'd10, 1'b1, 32'h0);
      if (c == 4) drive(4'd5, 32'hFFFF_FFFF, 32'h0, 5'd10, 1'b1, 32'h0);
      #1;
      if (c == 0 || c == 4) begin
        total++; if (ram_addr_o !== 17'h1FFFF) begin bad++; $display("FAIL lh_addr0 c=%0d got=%h exp=1ffff", c, ram_addr_o); end
      end
      if (c == 1 || c == 5) begin
        total++; if (ram_addr_o !== 17'h00000) begin bad++; $display("FAIL lh_addr1 c=%0d got=%h exp=00000", c, ram_addr_o); end
      end
      if (c == 3) begin
        total++; if (wdata_o !== 32'hFFFF_9234 || stallreq !== 1'b0) begin
          bad++; $display("FAIL lh_data got=%h/%b exp=ffff9234/0", wdata_o, stallreq); end
      end
      if (c == 7) begin
        total++; if (wdata_o !== 32'h0000_9234 || stallreq !== 1'b0) begin
          bad++; $display("FAIL lhu_data got=%h/%b exp=00009234/0", wdata_o, stallreq); end
      end
    end
    pulse_reset();
  endtask

  initial begin
    ram[17'h100]   = 8'h78;
    ram[17'h101]   = 8'h56;
    ram[17'h102]   = 8'h34;
    ram[17'h103]   = 8'h12;
    ram[17'h200]   = 8'h80;
    ram[17'h1FFFF] = 8'h34;
    ram[17'h00000] = 8'h92;
    test_reset();
    test_passthrough();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_reset_mid_op();
    test_lh_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
